// File: rtl/adc_capture_controller.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_controller
// Purpose  : Timed ADC AXI4-Stream capture into a buffer, drained as 128-bit FWFT words.
//            Define ADC_CAPTURE_HEADER_EN to write a trigger header entry before the beats.
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture_controller #(
    parameter int AXIS_DATA_WIDTH = 256,
    parameter int DEPTH_LOG2      = 9
) (
    input  logic                         s_axi_aclk,
    input  logic                         s_axi_aresetn,
    input  logic [AXIS_DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                         s00_axis_tvalid,
    output logic                         s00_axis_tready,
    input  logic [63:0]                  counter,
    input  logic                         arm,
    input  logic [63:0]                  start_time,
    input  logic [15:0]                  capture_len,
    input  logic                         abort,
    input  logic                         flush,
    input  logic                         fifo_rd,
    output logic [AXIS_DATA_WIDTH/2-1:0] fifo_dout,
    output logic                         fifo_empty,
    output logic [DEPTH_LOG2:0]          fifo_level,
    output logic                         busy,
    output logic                         done,
    output logic                         timestamp_error,
    output logic                         overflow_error
);
    localparam int                    c_HALF_W     = AXIS_DATA_WIDTH / 2;
    localparam int                    c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   c_LVL_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t                      r_state, w_state_nxt;
    logic [63:0]                 r_start_time;
    logic [15:0]                 r_capture_len;
    logic [15:0]                 r_remaining, w_remaining_nxt;
    logic                        r_done, w_done_nxt;
    logic                        r_ts_err, r_ovf_err, r_tready;
    logic                        w_ts_bad, w_arm_accept;
    logic                        w_wr_req;
    logic [AXIS_DATA_WIDTH-1:0]  w_wr_data;

    logic [AXIS_DATA_WIDTH-1:0]  r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0]       r_wr_ptr, r_rd_ptr;
    logic [DEPTH_LOG2:0]         r_level;
    logic                        r_rd_half;
    logic                        w_full, w_empty, w_do_wr, w_do_rd, w_do_pop, w_ovf_set;
    logic [AXIS_DATA_WIDTH-1:0]  w_head;

    assign w_ts_bad     = (start_time <= counter);
    assign w_arm_accept = (r_state == ST_IDLE) && arm && !abort;

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_wr_req        = 1'b0;
        w_wr_data       = s00_axis_tdata;
        w_done_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arm && !w_ts_bad) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (counter == r_start_time) begin
`ifdef ADC_CAPTURE_HEADER_EN
                    w_wr_req  = 1'b1;
                    w_wr_data = AXIS_DATA_WIDTH'({48'h0, r_capture_len, r_start_time});
`endif
                    if (r_capture_len == 16'd0) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt     = ST_CAPTURE;
                        w_remaining_nxt = r_capture_len;
                    end
                end
            end
            ST_CAPTURE: begin
                if (s00_axis_tvalid) begin
                    w_wr_req        = 1'b1;
                    w_remaining_nxt = r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Abort wins over everything, including the write of the cycle it lands in.
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_wr_req    = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state       <= ST_IDLE;
            r_start_time  <= 64'd0;
            r_capture_len <= 16'd0;
            r_remaining   <= 16'd0;
            r_done        <= 1'b0;
            r_ts_err      <= 1'b0;
            r_ovf_err     <= 1'b0;
            r_tready      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_done      <= w_done_nxt;
            r_tready    <= 1'b1;
            if (w_arm_accept) begin
                r_start_time  <= start_time;
                r_capture_len <= capture_len;
                r_ts_err      <= w_ts_bad;
                r_ovf_err     <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    // Full is judged on the pre-pop level, so a write against a full buffer drops even if a pop coincides.
    assign w_full    = (r_level == c_FULL_LEVEL);
    assign w_empty   = (r_level == '0);
    assign w_do_wr   = w_wr_req && !w_full && !flush;
    assign w_ovf_set = w_wr_req && w_full && !flush;
    assign w_do_rd   = fifo_rd && !w_empty && !flush;
    assign w_do_pop  = w_do_rd && r_rd_half;

    always_ff @(posedge s_axi_aclk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= w_wr_data;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_rd_half <= 1'b0;
        end else if (flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_rd_half <= 1'b0;
        end else begin
            if (w_do_wr)  r_wr_ptr  <= r_wr_ptr + c_PTR_ONE;
            if (w_do_rd)  r_rd_half <= ~r_rd_half;
            if (w_do_pop) r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
            if (w_do_wr && !w_do_pop)      r_level <= r_level + c_LVL_ONE;
            else if (!w_do_wr && w_do_pop) r_level <= r_level - c_LVL_ONE;
        end
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign fifo_dout       = w_empty ? '0 :
                             (r_rd_half ? w_head[AXIS_DATA_WIDTH-1:c_HALF_W] : w_head[c_HALF_W-1:0]);
    assign fifo_empty      = w_empty;
    assign fifo_level      = r_level;
    assign s00_axis_tready = r_tready;
    assign busy            = (r_state != ST_IDLE);
    assign done            = r_done;
    assign timestamp_error = r_ts_err;
    assign overflow_error  = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture_controller
// Purpose  : Directed table-driven bench for adc_capture_controller (8-entry buffer).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture_controller;
    localparam int DW  = 256;
    localparam int DL2 = 3;
`ifdef ADC_CAPTURE_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  tdata;
    logic           tvalid = 1'b1;
    logic           tready;
    logic [63:0]    counter = 64'd1000;
    logic           arm = 1'b0;
    logic [63:0]    start_time = 64'd0;
    logic [15:0]    capture_len = 16'd0;
    logic           abort = 1'b0;
    logic           flush = 1'b0;
    logic           fifo_rd = 1'b0;
    logic [127:0]   fifo_dout;
    logic           fifo_empty;
    logic [DL2:0]   fifo_level;
    logic           busy, done, ts_err, ovf_err;

    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input logic [63:0] c);
        return {~c, c + 64'h1111, c ^ 64'hDEAD_BEEF_0000_0000, c};
    endfunction

    assign tdata = pat(counter);

    adc_capture_controller #(.AXIS_DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s00_axis_tdata(tdata), .s00_axis_tvalid(tvalid), .s00_axis_tready(tready),
        .counter(counter), .arm(arm), .start_time(start_time), .capture_len(capture_len),
        .abort(abort), .flush(flush), .fifo_rd(fifo_rd),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
        .busy(busy), .done(done), .timestamp_error(ts_err), .overflow_error(ovf_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counter advances once per edge, like the TimeController register.
    task automatic tick();
        @(posedge clk);
        #1;
        counter = counter + 64'd1;
    endtask

    typedef struct {
        int off;
        int len;
        int abort_after;
        bit exp_ts;
        int exp_lvl_nohdr;
        int exp_lvl_hdr;
        bit exp_ovf;
        int exp_done;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vec_t          v;
        logic [63:0]   st;
        logic [255:0]  ent;
        int            exp_lvl, dcnt, guard;

        vecs[0] = '{20,  4, -1, 1'b0, 4, 5, 1'b0, 1};
        vecs[1] = '{ 0,  4, -1, 1'b1, 0, 0, 1'b0, 0};
        vecs[2] = '{ 5, 10, -1, 1'b0, 8, 8, 1'b1, 1};
        vecs[3] = '{ 3, 10,  2, 1'b0, 2, 3, 1'b0, 0};
        vecs[4] = '{ 3,  0, -1, 1'b0, 0, 1, 1'b0, 1};
        vecs[5] = '{-5,  3, -1, 1'b1, 0, 0, 1'b0, 0};
        vecs[6] = '{ 7,  1, -1, 1'b0, 1, 2, 1'b0, 1};

        // Reset state
        tick(); tick();
        chk("rst_tready", tready, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_dout", fifo_dout, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ts_err", ts_err, 0);
        chk("rst_ovf", ovf_err, 0);
        rst_n = 1'b1;
        tick();
        chk("tready_after_rst", tready, 1);

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            flush = 1'b1; tick(); flush = 1'b0;
            chk("flush_empty", fifo_empty, 1);
            chk("flush_level", fifo_level, 0);

            st = counter + longint'(v.off);
            arm = 1'b1; start_time = st; capture_len = v.len[15:0];
            tick();
            arm = 1'b0;
            chk("ts_err", ts_err, v.exp_ts);
            chk("busy_after_arm", busy, !v.exp_ts);

            dcnt = 0; guard = 0;
            while (busy && guard < 200) begin
                if (v.abort_after >= 0 && counter == st + longint'(v.abort_after + 1)) abort = 1'b1;
                tick(); guard++;
                if (done) dcnt++;
                if (abort) begin
                    abort = 1'b0;
                    chk("abort_busy", busy, 0);
                end
            end
            chk("capture_ends", busy, 0);
            tick();
            if (done) dcnt++;
            chk("done_count", dcnt, v.exp_done);
            exp_lvl = (HDR == 1) ? v.exp_lvl_hdr : v.exp_lvl_nohdr;
            chk("level", fifo_level, exp_lvl);
            chk("ovf", ovf_err, v.exp_ovf);

            for (int e = 0; e < exp_lvl; e++) begin
                if (HDR == 1 && e == 0) ent = {128'h0, 48'h0, v.len[15:0], st};
                else                    ent = pat(st + 64'(e - HDR + 1));
                chk("dout_lo", fifo_dout, ent[127:0]);
                fifo_rd = 1'b1; tick();
                chk("dout_hi", fifo_dout, ent[255:128]);
                tick(); fifo_rd = 1'b0;
            end
            chk("drained_empty", fifo_empty, 1);
        end

        // Read on empty is ignored; re-arm while busy is ignored.
        flush = 1'b1; tick(); flush = 1'b0;
        fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
        chk("rd_empty_level", fifo_level, 0);
        st = counter + 64'd6;
        arm = 1'b1; start_time = st; capture_len = 16'd2;
        tick();
        start_time = counter; capture_len = 16'd9;
        tick();
        arm = 1'b0;
        chk("rearm_ts_err", ts_err, 0);
        chk("rearm_busy", busy, 1);
        dcnt = 0; guard = 0;
        while (busy && guard < 100) begin
            tick(); guard++;
            if (done) dcnt++;
        end
        chk("rearm_ends", busy, 0);
        chk("rearm_done", dcnt, 1);
        chk("rearm_level", fifo_level, 2 + HDR);
        if (HDR == 1) ent = {128'h0, 48'h0, 16'd2, st};
        else          ent = pat(st + 64'd1);
        chk("rearm_first_lo", fifo_dout, ent[127:0]);

        // Flush coinciding with a beat write and a read.
        flush = 1'b1; tick(); flush = 1'b0;
        st = counter + 64'd3;
        arm = 1'b1; start_time = st; capture_len = 16'd6;
        tick();
        arm = 1'b0;
        guard = 0;
        while (counter != st + 64'd3 && guard < 50) begin
            tick(); guard++;
        end
        chk("pre_flush_level", fifo_level, 2 + HDR);
        flush = 1'b1; fifo_rd = 1'b1;
        tick();
        flush = 1'b0; fifo_rd = 1'b0;
        chk("flush_wr_empty", fifo_empty, 1);
        chk("flush_wr_level", fifo_level, 0);
        chk("flush_keeps_busy", busy, 1);
        guard = 0;
        while (busy && guard < 100) begin
            tick(); guard++;
        end
        chk("post_flush_ends", busy, 0);
        chk("post_flush_level", fifo_level, 3);
        ent = pat(st + 64'd4);
        chk("post_flush_head", fifo_dout, ent[127:0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_capture_controller.md
# adc_capture_controller

Receive-side counterpart of the DAC path: accepts the RFDC ADC AXI4-Stream, and on a timed trigger from the TimeController counter captures a programmed number of 256-bit beats into an internal buffer. Software drains the buffer as 128-bit words through a first-word-fall-through read port, which the AXI read-back bridge consumes. It sits beside the DAC controller, sharing the same 64-bit counter and the AXI clock domain; the ADC stream must already be synchronous to s_axi_aclk.

## Interface
- AXIS_DATA_WIDTH, 256, ADC beat width; fixed at 2×128.
- DEPTH_LOG2, 9, log2 of buffer depth in 256-bit entries.
- s_axi_aclk  in  1  sole clock, rising edge.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- s00_axis_tdata  in  256  ADC sample beat.
- s00_axis_tvalid  in  1  beat valid.
- s00_axis_tready  out  1  always 1 outside reset (ADC cannot be stalled).
- counter  in  64  global timestamp counter.
- arm  in  1  single-cycle request to start a capture.
- start_time  in  64  trigger timestamp, sampled on arm.
- capture_len  in  16  beats to capture, sampled on arm.
- abort  in  1  cancel capture.
- flush  in  1  empty the buffer.
- fifo_rd  in  1  pop one 128-bit word.
- fifo_dout  out  128  head word (valid when !fifo_empty).
- fifo_empty  out  1  no words available.
- fifo_level  out  DEPTH_LOG2+1  entries held (256-bit units).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at capture end.
- timestamp_error  out  1  last arm had start_time <= counter.
- overflow_error  out  1  sticky: a beat was dropped on full.

## Operation
- States: IDLE, WAIT, CAPTURE.
- IDLE: arm latches start_time/capture_len, clears overflow_error, sets timestamp_error = (start_time <= counter, unsigned). If error: stay IDLE; else → WAIT. arm in WAIT/CAPTURE ignored.
- WAIT: on counter == start_time write header entry (see Configuration), → CAPTURE with remaining = capture_len. capture_len == 0: → IDLE, done pulses.
- CAPTURE: each tvalid cycle counts one beat; beat written as one entry unless full (then dropped, overflow_error set). Beat that decrements remaining to 0 → IDLE, done pulse.
- Beats outside CAPTURE are discarded silently.
- abort (any state) → IDLE next edge, no write that cycle, no done; buffer retained. abort beats arm.
- flush: pointers and level cleared, read half-select reset; flush beats a simultaneous write or read. Does not change state.
- Read side: fifo_dout = low half of head entry, then high half; fifo_rd on high half pops entry. fifo_rd while empty ignored.
- Full judged on level before this cycle's pop; pop and write in same cycle: level unchanged.

## Timing
- Reset: state IDLE, all pointers/level 0, fifo_empty 1, fifo_dout 0, s00_axis_tready 0, busy/done/timestamp_error/overflow_error 0. tready 1 from first edge after release.
- arm at edge N → busy at N+1.
- counter == start_time sampled at edge T: header written at T; first beat accepted at T+1 edge; fifo_empty falls after T.
- Write → visible on fifo_dout next cycle.
- Last beat at edge L: done high for cycle after L, busy low same cycle.
- Counters/comparisons unsigned, no wrap handling on counter; remaining is 16-bit, no wrap.

## Configuration
- ADC_CAPTURE_HEADER_EN defined: header entry written at trigger, low half = {48'h0, capture_len, start_time}, high half = 128'h0; if buffer full, header dropped and overflow_error set.
- Undefined: no header; first entry is first captured beat; trigger cycle writes nothing.

## Test plan
- Header on, arm start_time=100, capture_len=4 at counter=50, tvalid continuous → at counter 100 header then 4 beats; fifo_level=5, reading 10 words yields {48'h0,16'd4,64'd100}, 0, then beats low/high in order; done one pulse.
- arm start_time=40 at counter=40 → timestamp_error=1, busy stays 0, nothing written.
- DEPTH_LOG2=2, capture_len=8, no reads → 4 entries held, overflow_error=1, done still pulses after 8 beats.
- abort two beats into capture_len=10 → busy 0 next cycle, no done, level=3 (header+2) retained.
- flush asserted same cycle as a beat write and fifo_rd → fifo_empty=1, level 0 next cycle.
- capture_len=0, header off → done pulses at trigger, buffer stays empty; second arm while busy ignored.
